// File: rtl/bcd_mod_counter_if.sv
// bcd_mod_counter_if: control, configuration and status bundle of the BCD modulo counter
interface bcd_mod_counter_if #(
    parameter int DIGITS = 2
);
    localparam int W = 4 * DIGITS;
    logic         en;
    logic         up_dn;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] limit;
    logic [W-1:0] cnt;
    logic         wrap;
    logic         load_err;
    logic         cfg_err;
    modport master (
        output en, up_dn, load, load_val, limit,
        input  cnt, wrap, load_err, cfg_err
    );
    modport slave (
        input  en, up_dn, load, load_val, limit,
        output cnt, wrap, load_err, cfg_err
    );
endinterface

// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter: packed-BCD up/down counter over 0..limit with load and wrap/error flags
module bcd_mod_counter #(
    parameter int DIGITS = 2
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    bcd_mod_counter_if.slave  bus
);
    localparam int W = 4 * DIGITS;

    logic [W-1:0] cnt_q, cnt_d;
    logic         wrap_q, wrap_d;
    logic         load_err_q, load_err_d;
    logic         cfg_err;
    logic         load_ok;

    function automatic logic is_bcd(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int k = 0; k < DIGITS; k++) ok = ok & (v[4*k+:4] <= 4'd9);
        return ok;
    endfunction

    // Ripple carry across digits: a digit advances only while all lower digits were 9.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic         c;
        logic [W-1:0] r;
        c = 1'b1;
        r = v;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k+:4] = !c ? v[4*k+:4] : (v[4*k+:4] == 4'd9 ? 4'd0 : v[4*k+:4] + 4'd1);
            c = c & (v[4*k+:4] == 4'd9);
        end
        return r;
    endfunction

    // Ripple borrow across digits: a digit steps back only while all lower digits were 0.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic         b;
        logic [W-1:0] r;
        b = 1'b1;
        r = v;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k+:4] = !b ? v[4*k+:4] : (v[4*k+:4] == 4'd0 ? 4'd9 : v[4*k+:4] - 4'd1);
            b = b & (v[4*k+:4] == 4'd0);
        end
        return r;
    endfunction

    assign cfg_err  = !is_bcd(bus.limit);
    assign load_ok  = is_bcd(bus.load_val) && (bus.load_val <= bus.limit);

    // Next state: a bad limit freezes everything, then load beats count enable.
    always_comb begin
        cnt_d      = cnt_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (!cfg_err) begin
            if (bus.load) begin
                cnt_d      = load_ok ? bus.load_val : cnt_q;
                load_err_d = !load_ok;
            end else if (bus.en) begin
                if (bus.up_dn) begin
                    wrap_d = cnt_q >= bus.limit;
                    cnt_d  = wrap_d ? '0 : bcd_inc(cnt_q);
                end else begin
                    wrap_d = cnt_q == '0;
                    cnt_d  = wrap_d ? bus.limit : bcd_dec(cnt_q);
                end
            end
        end
    end

    // State register with asynchronous clear.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt_q      <= '0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.cnt      = cnt_q;
    assign bus.wrap     = wrap_q;
    assign bus.load_err = load_err_q;
    assign bus.cfg_err  = cfg_err;
endmodule

// File: tb/tb_bcd_mod_counter.sv
// tb_bcd_mod_counter: randomized and directed checks of bcd_mod_counter against a decimal model
module tb_bcd_mod_counter;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   passes = 0;

    int   m_cnt = 0;
    bit   m_wrap = 0;
    bit   m_err = 0;
    logic [7:0] exp_c = 8'h00;

    bcd_mod_counter_if #(.DIGITS(2)) b ();
    bcd_mod_counter_if #(.DIGITS(4)) b4 ();

    bcd_mod_counter #(.DIGITS(2)) dut (.clk_i(clk), .reset_ni(reset_n), .bus(b));
    bcd_mod_counter #(.DIGITS(4)) dut4 (.clk_i(clk), .reset_ni(reset_n), .bus(b4));

    always #5 clk = ~clk;

    function automatic bit is_bcd(input logic [31:0] v, input int d);
        for (int i = 0; i < d; i++) if (v[4*i+:4] > 4'd9) return 0;
        return 1;
    endfunction

    function automatic int to_int(input logic [31:0] v, input int d);
        int r = 0;
        for (int i = d - 1; i >= 0; i--) r = r * 10 + int'(v[4*i+:4]);
        return r;
    endfunction

    function automatic logic [31:0] to_bcd(input int n, input int d);
        logic [31:0] r = '0;
        for (int i = 0; i < d; i++) begin
            r[4*i+:4] = 4'(n % 10);
            n = n / 10;
        end
        return r;
    endfunction

    // Drive one edge of the 2-digit counter and advance the decimal model alongside it.
    task automatic tick(input logic e, input logic ud, input logic ld, input logic [7:0] lv, input logic [7:0] lim);
        int lim_i;
        b.en = e; b.up_dn = ud; b.load = ld; b.load_val = lv; b.limit = lim;
        @(posedge clk);
        lim_i = to_int({24'h0, lim}, 2);
        m_wrap = 0;
        m_err = 0;
        if (!is_bcd({24'h0, lim}, 2)) begin
        end else if (ld) begin
            if (is_bcd({24'h0, lv}, 2) && to_int({24'h0, lv}, 2) <= lim_i) m_cnt = to_int({24'h0, lv}, 2);
            else m_err = 1;
        end else if (e) begin
            if (ud) begin
                if (m_cnt >= lim_i) begin m_cnt = 0; m_wrap = 1; end
                else m_cnt = m_cnt + 1;
            end else begin
                if (m_cnt == 0) begin m_cnt = lim_i; m_wrap = 1; end
                else m_cnt = m_cnt - 1;
            end
        end
        exp_c = 8'(to_bcd(m_cnt, 2));
        #1;
    endtask

    task automatic test_reset();
        b.en = 0; b.up_dn = 1; b.load = 0; b.load_val = 0; b.limit = 8'h15;
        b4.en = 0; b4.up_dn = 1; b4.load = 0; b4.load_val = 0; b4.limit = 16'h9999;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({b.cnt, b.wrap, b.load_err} !== 10'h0)
            $display("FAIL reset: cnt=%h wrap=%b err=%b expected 00 0 0", b.cnt, b.wrap, b.load_err);
        else passes++;
        @(negedge clk);
        reset_n = 1;
        m_cnt = 0; m_wrap = 0; m_err = 0;
    endtask

    task automatic test_legacy();
        for (int i = 0; i < 20; i++) begin
            tick(1, 1, 0, 8'h00, 8'h15);
            checks++;
            if ({b.cnt, b.wrap, b.load_err} !== {exp_c, m_wrap, m_err})
                $display("FAIL legacy[%0d]: cnt=%h wrap=%b err=%b expected cnt=%h wrap=%b err=%b",
                         i, b.cnt, b.wrap, b.load_err, exp_c, m_wrap, m_err);
            else passes++;
        end
    endtask

    task automatic test_down_borrow();
        tick(0, 0, 1, 8'h10, 8'h59);
        for (int i = 0; i < 12; i++) begin
            tick(1, 0, 0, 8'h00, 8'h59);
            checks++;
            if ({b.cnt, b.wrap, b.load_err} !== {exp_c, m_wrap, m_err})
                $display("FAIL down_borrow[%0d]: cnt=%h wrap=%b err=%b expected cnt=%h wrap=%b err=%b",
                         i, b.cnt, b.wrap, b.load_err, exp_c, m_wrap, m_err);
            else passes++;
        end
    endtask

    task automatic test_load();
        logic [7:0] vals [4] = '{8'h17, 8'h1A, 8'h30, 8'h23};
        for (int i = 0; i < 4; i++) begin
            tick(1, 1, 1, vals[i], 8'h23);
            checks++;
            if ({b.cnt, b.wrap, b.load_err} !== {exp_c, m_wrap, m_err})
                $display("FAIL load[%h]: cnt=%h wrap=%b err=%b expected cnt=%h wrap=%b err=%b",
                         vals[i], b.cnt, b.wrap, b.load_err, exp_c, m_wrap, m_err);
            else passes++;
            tick(0, 1, 0, 8'h00, 8'h23);
            checks++;
            if ({b.cnt, b.load_err} !== {exp_c, 1'b0})
                $display("FAIL load_pulse[%h]: cnt=%h err=%b expected cnt=%h err=0",
                         vals[i], b.cnt, b.load_err, exp_c);
            else passes++;
        end
    endtask

    task automatic test_limit_lowered();
        for (int dir = 1; dir >= 0; dir--) begin
            tick(0, 1, 1, 8'h40, 8'h59);
            tick(1, 1'(dir), 0, 8'h00, 8'h30);
            checks++;
            if ({b.cnt, b.wrap} !== (dir == 1 ? 9'h001 : 9'h072))
                $display("FAIL limit_lowered dir=%0d: cnt=%h wrap=%b expected %s",
                         dir, b.cnt, b.wrap, dir == 1 ? "00 wrap=1" : "39 wrap=0");
            else passes++;
        end
    endtask

    task automatic test_limit_zero();
        for (int i = 0; i < 6; i++) begin
            tick(1, 1'(i < 3), 0, 8'h00, 8'h00);
            checks++;
            if ({b.cnt, b.wrap} !== 9'h001)
                $display("FAIL limit_zero[%0d]: cnt=%h wrap=%b expected 00 wrap=1", i, b.cnt, b.wrap);
            else passes++;
        end
    endtask

    task automatic test_async_reset();
        tick(0, 1, 1, 8'h37, 8'h59);
        #3;
        reset_n = 0;
        #1;
        checks++;
        if ({b.cnt, b.wrap, b.load_err} !== 10'h0)
            $display("FAIL async_reset: cnt=%h wrap=%b err=%b expected 00 0 0", b.cnt, b.wrap, b.load_err);
        else passes++;
        m_cnt = 0; m_wrap = 0; m_err = 0;
        @(negedge clk);
        reset_n = 1;
        tick(1, 1, 0, 8'h00, 8'h59);
        checks++;
        if ({b.cnt, b.wrap} !== 9'h002)
            $display("FAIL after_reset: cnt=%h wrap=%b expected 01 wrap=0", b.cnt, b.wrap);
        else passes++;
    endtask

    task automatic test_cfg_err();
        tick(0, 1, 1, 8'h12, 8'h29);
        b.limit = 8'h2F;
        #1;
        checks++;
        if (b.cfg_err !== 1'b1) $display("FAIL cfg_err_flag: cfg_err=%b expected 1", b.cfg_err);
        else passes++;
        tick(1, 1, 0, 8'h00, 8'h2F);
        tick(1, 0, 1, 8'h05, 8'h2F);
        checks++;
        if ({b.cnt, b.wrap, b.load_err} !== {8'h12, 2'b00})
            $display("FAIL cfg_err_hold: cnt=%h wrap=%b err=%b expected 12 0 0", b.cnt, b.wrap, b.load_err);
        else passes++;
        tick(1, 1, 0, 8'h00, 8'h29);
        checks++;
        if ({b.cnt, b.cfg_err} !== {8'h13, 1'b0})
            $display("FAIL cfg_err_resume: cnt=%h cfg_err=%b expected 13 0", b.cnt, b.cfg_err);
        else passes++;
    endtask

    task automatic test_random();
        logic [7:0] lim, lv;
        for (int i = 0; i < 400; i++) begin
            lim = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'(to_bcd($urandom_range(0, 99), 2));
            if ($urandom_range(0, 3) != 0) lim = 8'h47;
            lv  = $urandom_range(0, 1) ? 8'($urandom) : 8'(to_bcd($urandom_range(0, 99), 2));
            tick(1'($urandom_range(0, 9) < 7), 1'($urandom), 1'($urandom_range(0, 4) == 0), lv, lim);
            checks++;
            if ({b.cnt, b.wrap, b.load_err, b.cfg_err} !== {exp_c, m_wrap, m_err, !is_bcd({24'h0, lim}, 2)})
                $display("FAIL random[%0d] lim=%h: cnt=%h wrap=%b err=%b cfg=%b expected cnt=%h wrap=%b err=%b",
                         i, lim, b.cnt, b.wrap, b.load_err, b.cfg_err, exp_c, m_wrap, m_err);
            else passes++;
        end
    endtask

    task automatic test_wide();
        logic [15:0] lv   [4] = '{16'h9999, 16'h0999, 16'h1000, 16'h0000};
        logic        ud   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [15:0] expc [4] = '{16'h0000, 16'h1000, 16'h0999, 16'h9999};
        logic        expw [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            b4.limit = 16'h9999; b4.load = 1; b4.load_val = lv[i]; b4.en = 0; b4.up_dn = ud[i];
            @(posedge clk); #1;
            b4.load = 0; b4.en = 1;
            @(posedge clk); #1;
            b4.en = 0;
            checks++;
            if ({b4.cnt, b4.wrap} !== {expc[i], expw[i]})
                $display("FAIL wide[%h]: cnt=%h wrap=%b expected cnt=%h wrap=%b",
                         lv[i], b4.cnt, b4.wrap, expc[i], expw[i]);
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_legacy();
        test_down_borrow();
        test_load();
        test_limit_lowered();
        test_limit_zero();
        test_async_reset();
        test_cfg_err();
        test_random();
        test_wide();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/bcd_mod_counter.md
# bcd_mod_counter

Parametrised multi-digit BCD counter with a runtime-programmable terminal value, up/down direction, count enable and synchronous parallel load. It is the general successor of the fixed two-digit 00–15 counter. Configured with DIGITS=2 and limit=15 it reproduces that sequence, and it also serves clock/timer displays (00–59, 00–23, and so on) and event counters. Outputs are packed BCD, one nibble per decimal digit, least-significant digit in bits [3:0].

## Interface
- DIGITS, 2, number of BCD digits (1–8); count bus width W = 4*DIGITS.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  count enable; one step per clock while high.
- up_dn  input  1  direction: 1 = count up, 0 = count down.
- load  input  1  synchronous parallel load request; has priority over en.
- load_val  input  W  packed-BCD value to load.
- limit  input  W  packed-BCD terminal value; the count range is 0..limit inclusive.
- cnt  output  W  current count, packed BCD, registered.
- wrap  output  1  registered one-cycle pulse: the count wrapped on the last edge.
- load_err  output  1  registered one-cycle pulse: the last load was rejected.
- cfg_err  output  1  combinational: limit contains a non-BCD nibble (A–F).

## Operation
- Reset (reset=0, asynchronous): cnt=0, wrap=0, load_err=0. Release is synchronous to the next clk edge. A reset mid-count discards state immediately.
- Priority per edge: cfg_err, then load, then en, then hold.
- cfg_err=1: cnt holds and load is ignored. wrap=0 and load_err=0 for that edge.
- load=1: the value is accepted when every load_val nibble is ≤9 and load_val ≤ limit.
  - Accepted: cnt←load_val, wrap=0.
  - Rejected: cnt holds, load_err=1.
  - en is ignored on any load edge.
- en=1, up_dn=1:
  - If cnt ≥ limit: cnt←0 and wrap=1. The ≥ comparison covers limit being lowered below cnt mid-count.
  - Otherwise: BCD increment. A digit at 9 goes to 0 and carries into the next digit. Carry out of the top digit cannot occur, because limit is ≤ all-9s.
- en=1, up_dn=0:
  - If cnt=0: cnt←limit and wrap=1.
  - Otherwise: BCD decrement. A digit at 0 goes to 9 and borrows from the next digit.
  - A cnt above limit (after limit was lowered) decrements normally, with no clamp.
- en=0 and no load: cnt holds, wrap=0, load_err=0.
- Comparisons (≥, ≤, =0) are done on packed BCD as unsigned binary, which is order-preserving for valid BCD.
- limit=0: in both directions every enabled edge gives cnt=0 and wrap=1.
- up_dn may change on any cycle. The new direction applies on the next enabled edge with no dead cycle.

## Timing
- All outputs except cfg_err are registered. cnt, wrap and load_err update together on the same rising edge.
- Latency is one clock from sampled en/load/up_dn/load_val to cnt.
- wrap is high for exactly the one cycle in which cnt shows the wrapped value (0 going up, limit going down).
- Consecutive wrapping edges (e.g. limit=0, en held) hold wrap high continuously, one pulse per edge.
- limit is sampled on every edge. It is static in normal use, but a change takes effect on the next edge.
- No multi-cycle paths. Carry and borrow chains are combinational across DIGITS nibbles within one cycle.

## Test plan
- Legacy sequence: DIGITS=2, limit=0x15, up_dn=1, en=1 for 20 edges after reset release.
  - Required: cnt = 0x00,0x01..0x09,0x10..0x15,0x00,...
  - wrap high only in the cycle cnt returns to 0x00.
- Down count with borrow: limit=0x59, load 0x10, up_dn=0, en=1.
  - Required: 0x09, 0x08, ..., 0x00, then 0x59 with wrap=1.
- Load priority and rejection (limit=0x23):
  - load=1, en=1, load_val=0x17: cnt=0x17 next cycle, no increment.
  - load_val=0x1A: cnt holds, load_err pulses once.
  - load_val=0x30: cnt holds, load_err pulses once.
- Limit lowered mid-count: count up to 0x40 with limit=0x59, then set limit=0x30.
  - Next up edge: cnt=0x00, wrap=1.
  - If instead down: cnt=0x39.
- Async reset mid-operation: assert reset between edges while cnt=0x37.
  - cnt=0, wrap=0, load_err=0 immediately, without a clk edge.
  - After release, the first enabled up edge gives 0x01.
- Config error and hold: limit=0x2F.
  - cfg_err=1, cnt frozen across en and load.
  - Restoring limit=0x29 resumes counting from the frozen value.
  - DIGITS=4, limit=0x9999: 9999→0000 with wrap.
